mips_run_dump_ctrl: RTL and testbench

Synthesizable run-and-dump controller for the single-cycle MIPS core. On `start` it enables the core for a programmable number of clock cycles, or until the core signals halt. It then reads out the register file and data memory word by word over a valid/ready stream, so end-of-program state can be captured by a bench or an external host without hierarchical references.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/mips_run_dump_ctrl_if.sv | 45 ++++
 rtl/mips_sat_counter.sv | 31 +++
 rtl/mips_run_dump_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mips_run_dump_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS run-and-dump controller.
//   state_e       - controller FSM states
//   DUMP_SEL_REG  - dump phase / dump_sel value for register-file words
//   DUMP_SEL_MEM  - dump phase / dump_sel value for data-memory words
//   addr_w()      - address width for an N-entry array (never below 1 bit)
//   max_u()       - unsigned maximum, for sizing the shared dump index
package mips_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFetch,
        StCapture,
        StPresent,
        StDone
    } state_e;

    localparam logic DUMP_SEL_REG = 1'b0;
    localparam logic DUMP_SEL_MEM = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // A single-entry array still needs a 1-bit address port.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips_run_dump_ctrl_if.sv
// mips_run_dump_ctrl_if: host/core/dump-stream signal bundle of the run-and-dump controller.
//   Run control : start, run_cycles, core_halt, core_en, cycles_run, busy, done
//   Read ports  : reg_raddr/reg_rdata, mem_raddr/mem_rdata (1-cycle read latency)
//   Dump stream : dump_valid/dump_ready, dump_data, dump_sel, dump_addr
// Modports: master = controller side, slave = host/core/memory side.
interface mips_run_dump_ctrl_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned CYC_W     = 16
);
    localparam int unsigned RA_W = mips_pkg::addr_w(REG_COUNT);
    localparam int unsigned MA_W = mips_pkg::addr_w(MEM_DEPTH);
    localparam int unsigned DA_W = mips_pkg::addr_w(mips_pkg::max_u(REG_COUNT, MEM_DEPTH));

    logic              start;
    logic [CYC_W-1:0]  run_cycles;
    logic              core_halt;
    logic              core_en;
    logic [RA_W-1:0]   reg_raddr;
    logic [DATA_W-1:0] reg_rdata;
    logic [MA_W-1:0]   mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_sel;
    logic [DA_W-1:0]   dump_addr;
    logic [CYC_W-1:0]  cycles_run;
    logic              busy;
    logic              done;

    modport master (
        input  start, run_cycles, core_halt, reg_rdata, mem_rdata, dump_ready,
        output core_en, reg_raddr, mem_raddr, dump_valid, dump_data, dump_sel, dump_addr,
               cycles_run, busy, done
    );

    modport slave (
        output start, run_cycles, core_halt, reg_rdata, mem_rdata, dump_ready,
        input  core_en, reg_raddr, mem_raddr, dump_valid, dump_data, dump_sel, dump_addr,
               cycles_run, busy, done
    );

endinterface

// File: rtl/mips_sat_counter.sv
// mips_sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clock   - rising-edge clock
//   reset   - asynchronous active-high reset, clears the count
//   i_clr   - synchronous clear (wins over i_en)
//   i_en    - count up by one
//   o_count - current count
module mips_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mips_run_dump_ctrl.sv
// mips_run_dump_ctrl: runs the MIPS core for a cycle budget (or until halt), then streams the
// register file and, optionally, data memory out over a valid/ready dump interface.
//   clock - rising-edge clock
//   reset - asynchronous active-high reset, returns everything to idle
//   bus   - mips_run_dump_ctrl_if.master: start/budget/halt in, core_en out, read ports to the
//           register file and data memory, dump stream out, cycles_run/busy/done status.
// Build option: define MIPS_DUMP_MEM_EN to include the data-memory dump phase. Without it only
// the registers are dumped, mem_raddr is tied to 0 and dump_sel stays 0.
module mips_run_dump_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned CYC_W     = 16
) (
    input logic                clock,
    input logic                reset,
    mips_run_dump_ctrl_if.master bus
);

    localparam int unsigned RA_W = addr_w(REG_COUNT);
    localparam int unsigned MA_W = addr_w(MEM_DEPTH);
    localparam int unsigned DA_W = addr_w(max_u(REG_COUNT, MEM_DEPTH));

    localparam logic [DA_W-1:0] REG_LAST = DA_W'(REG_COUNT - 1);
    localparam logic [DA_W-1:0] MEM_LAST = DA_W'(MEM_DEPTH - 1);

`ifdef MIPS_DUMP_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    state_e            r_state;
    state_e            w_state_next;
    logic [CYC_W-1:0]  r_budget;
    logic              r_phase;
    logic [DA_W-1:0]   r_index;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_sel;
    logic [DA_W-1:0]   r_dump_addr;

    logic              w_start_ok;
    logic              w_cnt_en;
    logic [CYC_W-1:0]  w_cycles_run;
    logic [CYC_W:0]    w_cnt_inc;
    logic              w_run_last;
    logic              w_hs;
    logic              w_at_last;
    logic              w_reading;

    logic              w_core_en;
    logic              w_busy;
    logic              w_done;
    logic              w_dump_valid;
    logic [RA_W-1:0]   w_reg_raddr;
    logic [MA_W-1:0]   w_mem_raddr;

    assign w_start_ok = (r_state == StIdle) && bus.start;
    assign w_cnt_en   = (r_state == StRun);

    mips_sat_counter #(
        .W (CYC_W)
    ) u_cycles (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (w_start_ok),
        .i_en    (w_cnt_en),
        .o_count (w_cycles_run)
    );

    // One bit wider so the +1 compare cannot alias when the count is all-ones.
    assign w_cnt_inc  = {1'b0, w_cycles_run} + {{CYC_W{1'b0}}, 1'b1};
    assign w_run_last = (w_cnt_inc == {1'b0, r_budget});
    assign w_hs       = (r_state == StPresent) && bus.dump_ready;
    assign w_at_last  = (r_phase == DUMP_SEL_MEM) ? (r_index == MEM_LAST) : (r_index == REG_LAST);
    assign w_reading  = (r_state == StFetch) || (r_state == StCapture);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = (bus.run_cycles == '0) ? StFetch : StRun;
                end
            end
            StRun: begin
                if (w_run_last || bus.core_halt) begin
                    w_state_next = StFetch;
                end
            end
            StFetch:   w_state_next = StCapture;
            StCapture: w_state_next = StPresent;
            StPresent: begin
                if (w_hs) begin
                    if (!w_at_last) begin
                        w_state_next = StFetch;
                    end else if (MEM_EN && (r_phase == DUMP_SEL_REG)) begin
                        w_state_next = StFetch;
                    end else begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        w_core_en    = (r_state == StRun);
        w_busy       = (r_state != StIdle);
        w_done       = (r_state == StDone);
        w_dump_valid = (r_state == StPresent);
        w_reg_raddr  = '0;
        w_mem_raddr  = '0;
        if (w_reading && (r_phase == DUMP_SEL_REG)) begin
            w_reg_raddr = r_index[RA_W-1:0];
        end
`ifdef MIPS_DUMP_MEM_EN
        if (w_reading && (r_phase == DUMP_SEL_MEM)) begin
            w_mem_raddr = r_index[MA_W-1:0];
        end
`endif
    end

    // Budget, dump phase/index and the captured dump word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_budget    <= '0;
            r_phase     <= DUMP_SEL_REG;
            r_index     <= '0;
            r_dump_data <= '0;
            r_dump_sel  <= DUMP_SEL_REG;
            r_dump_addr <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_budget <= bus.run_cycles;
                        r_phase  <= DUMP_SEL_REG;
                        r_index  <= '0;
                    end
                end
                StCapture: begin
                    // Read data for the address driven in FETCH arrives this cycle.
                    r_dump_data <= (r_phase == DUMP_SEL_MEM) ? bus.mem_rdata : bus.reg_rdata;
                    r_dump_sel  <= r_phase;
                    r_dump_addr <= r_index;
                end
                StPresent: begin
                    if (w_hs) begin
                        if (!w_at_last) begin
                            r_index <= r_index + 1'b1;
                        end else if (MEM_EN && (r_phase == DUMP_SEL_REG)) begin
                            r_index <= '0;
                            r_phase <= DUMP_SEL_MEM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.core_en    = w_core_en;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.dump_valid = w_dump_valid;
    assign bus.reg_raddr  = w_reg_raddr;
    assign bus.mem_raddr  = w_mem_raddr;
    assign bus.dump_data  = r_dump_data;
    assign bus.dump_sel   = r_dump_sel;
    assign bus.dump_addr  = r_dump_addr;
    assign bus.cycles_run = w_cycles_run;

endmodule

// File: tb/tb_mips_run_dump_ctrl.sv
// tb_mips_run_dump_ctrl: randomized self-checking bench for mips_run_dump_ctrl with
// REG_COUNT=4 and MEM_DEPTH=4. A per-run reference computes the expected enabled-cycle count
// and the expected ordered list of dump words from the stored register/memory contents.
module tb_mips_run_dump_ctrl;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_COUNT = 4;
    localparam int unsigned MEM_DEPTH = 4;
    localparam int unsigned CYC_W     = 16;

`ifdef MIPS_DUMP_MEM_EN
    localparam bit MemEn = 1'b1;
`else
    localparam bit MemEn = 1'b0;
`endif

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic [31:0] data;
    } word_t;

    logic clock;
    logic reset;

    mips_run_dump_ctrl_if #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .MEM_DEPTH (MEM_DEPTH),
        .CYC_W     (CYC_W)
    ) bus ();

    mips_run_dump_ctrl #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .MEM_DEPTH (MEM_DEPTH),
        .CYC_W     (CYC_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] regs_m [REG_COUNT];
    logic [31:0] mems_m [MEM_DEPTH];

    // Synchronous-read storage, one cycle of latency
    always_ff @(posedge clock) begin
        bus.reg_rdata <= regs_m[bus.reg_raddr];
        bus.mem_rdata <= mems_m[bus.mem_raddr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_core_en"},    bus.core_en,    0);
        check_eq({pfx, "_dump_valid"}, bus.dump_valid, 0);
        check_eq({pfx, "_dump_data"},  bus.dump_data,  0);
        check_eq({pfx, "_dump_sel"},   bus.dump_sel,   0);
        check_eq({pfx, "_dump_addr"},  bus.dump_addr,  0);
        check_eq({pfx, "_cycles_run"}, bus.cycles_run, 0);
        check_eq({pfx, "_busy"},       bus.busy,       0);
        check_eq({pfx, "_done"},       bus.done,       0);
        check_eq({pfx, "_reg_raddr"},  bus.reg_raddr,  0);
        check_eq({pfx, "_mem_raddr"},  bus.mem_raddr,  0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(REG_COUNT); i++) regs_m[i] = $urandom;
        for (int i = 0; i < int'(MEM_DEPTH); i++) mems_m[i] = $urandom;
    endtask

    // One complete start/run/dump transaction.
    //   budget  : run_cycles value; halt_at: enabled cycle (1-based) that raises core_halt, 0=none
    //   rdy_pct : chance of dump_ready each cycle
    //   bp_pos  : dump word (position in stream) on which ready is forced low for bp_len cycles
    //   abort   : assert reset while REG word 1 is presented
    task automatic run_one(input int budget, input int halt_at, input int rdy_pct,
                           input int bp_pos, input int bp_len, input bit abort);
        word_t exp_q[$];
        word_t w;
        word_t prev;
        int    exp_en, en_cnt, cyc, first_valid, popped, total, hold;
        bit    fin, aborted, prev_stall, last_hs;

        // Reference: enabled cycles are the budget, cut short by a halt inside it
        if (budget == 0)                          exp_en = 0;
        else if (halt_at > 0 && halt_at < budget) exp_en = halt_at;
        else                                      exp_en = budget;

        for (int i = 0; i < int'(REG_COUNT); i++) begin
            w.sel = 1'b0; w.addr = 2'(i); w.data = regs_m[i];
            exp_q.push_back(w);
        end
        if (MemEn) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                w.sel = 1'b1; w.addr = 2'(i); w.data = mems_m[i];
                exp_q.push_back(w);
            end
        end
        total = exp_q.size();

        en_cnt = 0; cyc = 0; first_valid = -1; popped = 0; hold = 0;
        fin = 0; aborted = 0; prev_stall = 0; last_hs = 0;
        prev.sel = 0; prev.addr = 0; prev.data = 0;

        @(negedge clock);
        bus.start      = 1'b1;
        bus.run_cycles = CYC_W'(budget);
        bus.core_halt  = 1'b0;
        bus.dump_ready = 1'b0;
        @(posedge clock);
        #1;
        check_eq("core_en_first", bus.core_en, (exp_en > 0));
        check_eq("busy_after_start", bus.busy, 1);
        check_eq("cycles_cleared", bus.cycles_run, 0);

        while (!fin && !aborted && cyc < 400) begin
            bus.start      = bus.done ? 1'b0 : 1'($urandom_range(0, 1));
            bus.run_cycles = CYC_W'($urandom);
            if (bus.core_en) begin
                bus.core_halt = (halt_at > 0) && (en_cnt + 1 == halt_at);
                en_cnt++;
                check_eq("raddr_in_run", {bus.reg_raddr, bus.mem_raddr}, 0);
            end else begin
                bus.core_halt = 1'($urandom_range(0, 1));
            end
            if (last_hs) check_eq("valid_gap", bus.dump_valid, 0);
            last_hs = 0;
            bus.dump_ready = 1'($urandom_range(0, 1));

            if (bus.dump_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check_eq("raddr_in_present", {bus.reg_raddr, bus.mem_raddr}, 0);
                if (prev_stall) begin
                    check_eq("hold_data", bus.dump_data, prev.data);
                    check_eq("hold_sel",  bus.dump_sel,  prev.sel);
                    check_eq("hold_addr", bus.dump_addr, prev.addr);
                end
                if (popped == bp_pos && hold < bp_len) begin
                    bus.dump_ready = 1'b0;
                    hold++;
                end else begin
                    bus.dump_ready = ($urandom_range(0, 99) < rdy_pct);
                end
                if (abort && popped == 1) begin
                    bus.dump_ready = 1'b0;
                    #1 reset = 1'b1;
                    #1 check_reset_outputs("midreset");
                    @(negedge clock);
                    reset = 1'b0;
                    aborted = 1;
                end else if (bus.dump_ready) begin
                    w = exp_q.pop_front();
                    check_eq("word_data", bus.dump_data, w.data);
                    check_eq("word_sel",  bus.dump_sel,  w.sel);
                    check_eq("word_addr", bus.dump_addr, w.addr);
                    popped++;
                    prev_stall = 0;
                    last_hs = 1;
                end else begin
                    prev_stall = 1;
                    prev.data = bus.dump_data;
                    prev.sel  = bus.dump_sel;
                    prev.addr = bus.dump_addr;
                end
            end

            if (bus.done) begin
                fin = 1;
                check_eq("words_at_done", popped, total);
                bus.start = 1'b0;
            end
            if (!aborted) begin
                @(posedge clock);
                #1;
                cyc++;
            end
        end

        bus.start     = 1'b0;
        bus.core_halt = 1'b0;
        if (!aborted) begin
            check_eq("done_seen", fin, 1);
            check_eq("done_single_pulse", bus.done, 0);
            check_eq("busy_idle", bus.busy, 0);
            check_eq("cycles_run", bus.cycles_run, exp_en);
            check_eq("core_en_cycles", en_cnt, exp_en);
            check_eq("first_valid_cycle", first_valid, exp_en + 2);
            // cycles_run must hold while idle
            @(posedge clock);
            #1;
            check_eq("cycles_run_hold", bus.cycles_run, exp_en);
        end
    endtask

    int bp_pos;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.start      = 1'b0;
        bus.run_cycles = '0;
        bus.core_halt  = 1'b0;
        bus.dump_ready = 1'b0;
        for (int i = 0; i < int'(REG_COUNT); i++) regs_m[i] = 32'(i);
        for (int i = 0; i < int'(MEM_DEPTH); i++) mems_m[i] = $urandom;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Budget run, registers hold 0..3
        run_one(9, 0, 100, -1, 0, 1'b0);
        // Early halt at the 5th enabled cycle
        run_one(100, 5, 100, -1, 0, 1'b0);
        // Halt coincides with the last budgeted cycle
        run_one(4, 4, 100, -1, 0, 1'b0);
        // Zero budget
        run_one(0, 0, 100, -1, 0, 1'b0);
        // Backpressure on MEM word 2 (REG word 2 when only registers are dumped)
        bp_pos = MemEn ? 6 : 2;
        mems_m[2] = 32'hDEADBEEF;
        regs_m[2] = MemEn ? regs_m[2] : 32'hDEADBEEF;
        run_one(6, 0, 100, bp_pos, 7, 1'b0);
        // Reset during REG word 1, then a clean dump from REG:0
        fill_random();
        run_one(3, 0, 100, -1, 0, 1'b1);
        check_reset_outputs("after_reset");
        run_one(3, 0, 100, -1, 0, 1'b0);

        for (int k = 0; k < 15; k++) begin
            fill_random();
            run_one($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(30, 100),
                    $urandom_range(0, 7), $urandom_range(0, 5), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
